// File: rtl/unstriping_pkg.sv
// Shared constants and helpers for the byte un-striping stage.
package unstriping_pkg;

  localparam int DEF_LANES = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // Width of an index into n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A request for zero lanes still runs one lane; never exceed the built lanes.
  function automatic int clamp_lanes(input int req, input int lanes);
    if (req < 1) return 1;
    if (req > lanes) return lanes;
    return req;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_wr, do_rd;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // A pop frees the slot the same edge, so a full FIFO may still accept a word.
  assign do_rd = pop_i && !empty_o;
  assign do_wr = push_i && (!full_o || do_rd);

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_wr};
    rd_d = rd_q + {{AW{1'b0}}, do_rd};
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/byte_unstriping_n.sv
// Recombines a round-robin striped word stream from LANES lanes into one stream,
// with per-lane skew FIFOs and a runtime-selectable active lane count.
module byte_unstriping_n
  import unstriping_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES*WIDTH-1:0]        lane_data,
  input  logic [LANES-1:0]              lane_valid,
  input  logic [$clog2(LANES+1)-1:0]    active_lanes,
  output logic [WIDTH-1:0]              data_out,
  output logic                          valid_out,
  output logic [clog2_min1(LANES)-1:0]  out_lane,
  output logic [LANES-1:0]              overflow
);

  localparam int NW = $clog2(LANES + 1);
  localparam int RW = clog2_min1(LANES);

  logic [WIDTH-1:0] head [LANES];
  logic [LANES-1:0] full, empty;
  logic [LANES-1:0] push_v, pop_v, flush_v, ovf_set;

  logic [RW-1:0]    rr_q, rr_d;
  logic [NW-1:0]    n_act_q, n_act_d, n_req;
  logic [WIDTH-1:0] data_q, data_d, head_sel;
  logic [RW-1:0]    lane_q, lane_d;
  logic             valid_q, valid_d;
  logic [LANES-1:0] ovf_q, ovf_d;
  logic             pop_en, sample;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .flush_i (flush_v[g]),
      .push_i  (push_v[g]),
      .pop_i   (pop_v[g]),
      .din_i   (lane_data[g*WIDTH +: WIDTH]),
      .head_o  (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  always_comb begin
    head_sel = '0;
    pop_en   = 1'b0;
    pop_v    = '0;
    push_v   = '0;
    flush_v  = '0;
    ovf_set  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (RW'(i) == rr_q) begin
        head_sel = head[i];
        pop_en   = !empty[i];
        pop_v[i] = !empty[i];
      end
    end
    // Lane count may only change at a stripe boundary while lane 0 is still awaited.
    sample = (rr_q == '0) && !pop_en;
    n_req  = NW'(clamp_lanes(int'(active_lanes), LANES));
    for (int i = 0; i < LANES; i++) begin
      push_v[i]  = lane_valid[i] && (NW'(i) < n_act_q);
      flush_v[i] = sample && (NW'(i) >= n_req);
      ovf_set[i] = push_v[i] && full[i] && !pop_v[i] && !flush_v[i];
    end
    rr_d = rr_q;
    if (pop_en) rr_d = (int'(rr_q) + 1 >= int'(n_act_q)) ? '0 : rr_q + 1'b1;
    n_act_d = sample ? n_req : n_act_q;
    data_d  = pop_en ? head_sel : data_q;
    lane_d  = pop_en ? rr_q : lane_q;
    valid_d = pop_en;
    ovf_d   = ovf_q | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q    <= '0;
      n_act_q <= NW'(LANES);
      data_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      n_act_q <= n_act_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign out_lane  = lane_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/byte_unstriping_n.md
# byte_unstriping_n

Parametrised byte un-striping stage: recombines a word stream striped round-robin across `LANES` physical lanes into a single `WIDTH`-bit output stream. Sits on the receive side after the per-lane PHY/deserialiser logic, feeding the link-layer consumer. Per-lane FIFOs absorb inter-lane skew of up to `DEPTH` words. The active lane count is runtime-selectable for degraded-link operation.

## Interface
Parameters:
- `LANES`, 2, number of physical lanes (≥1).
- `WIDTH`, 32, word width per lane and of output.
- `DEPTH`, 4, per-lane FIFO depth in words (power of two, ≥2).

Ports:
- One clock; reset is synchronous and active-high. Ports are named `clk` and `reset`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `lane_data`  in  LANES*WIDTH  lane i word at bits [i*WIDTH +: WIDTH].
- `lane_valid`  in  LANES  lane i word valid this cycle.
- `active_lanes`  in  $clog2(LANES+1)  number of lanes in use (lanes 0..n-1).
- `data_out`  out  WIDTH  recombined word.
- `valid_out`  out  1  `data_out` valid this cycle.
- `out_lane`  out  $clog2(LANES) (min 1)  lane index that supplied `data_out`.
- `overflow`  out  LANES  sticky per-lane overflow flag.

## Operation
- Reset: all FIFOs empty, read pointer `rr` = 0, `data_out` = 0, `valid_out` = 0, `out_lane` = 0, `overflow` = 0, registered lane count `n_act` = LANES.
- Push: lane i with `lane_valid[i]`=1 and i < `n_act` writes `lane_data` word into FIFO i. Lanes ≥ `n_act` are ignored (no push, no overflow).
- Push into full FIFO i (without same-cycle pop of FIFO i): word dropped, `overflow[i]` set; cleared only by `reset`.
- Pop: each cycle, if FIFO `rr` is non-empty, pop its head into `data_out`, `valid_out`=1, `out_lane`=`rr`, and advance `rr`. `rr` wraps to 0 after `n_act`-1.
- If FIFO `rr` is empty: stall — `valid_out`=0, `rr` unchanged, `data_out`/`out_lane` hold previous values. Output order is strictly lane 0,1,…,n_act-1,0,… regardless of arrival order.
- `n_act` update: `active_lanes` is sampled into `n_act` only on a cycle when `rr` = 0 and a pop from lane 0 does not occur (i.e. at stripe boundary while waiting for lane 0) or on reset release. Value 0 clamps to 1; values > LANES clamp to LANES. On change, FIFOs of newly disabled lanes are flushed.
- Simultaneous push and pop on same FIFO: both take effect; on a full FIFO this is not an overflow.

## Timing
- Latency: word sampled at edge t into an empty FIFO whose lane is `rr` appears on `data_out` with `valid_out`=1 after edge t+1 (no combinational bypass).
- Peak throughput: one word per cycle; sustained rate equals aggregate lane rate as long as skew ≤ DEPTH words.
- `overflow` asserts the cycle after the dropping edge.
- Reset mid-operation: all stored words discarded, outputs return to reset values after the reset edge; inputs during reset are ignored.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package `unstriping_pkg`: default `LANES`/`WIDTH`/`DEPTH` constants, `function clog2_min1`, lane-count clamp function.
- One sub-module: `lane_fifo` (sync FIFO, `WIDTH`×`DEPTH`, outputs `full`/`empty`/head word, pointer-wrap with extra MSB), instantiated `LANES` times via generate.
- Top holds `rr`, `n_act`, output registers, overflow flags.

## Test plan
- Default 2-lane, aligned-with-1-cycle-skew: lane0 FFFFFFFF at edge 3, lane1 EEEEEEEE at edge 4, lane0 DDDDDDDD edge 5, lane1 CCCCCCCC edge 6 -> `data_out` FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on consecutive valid cycles starting after edge 4, `out_lane` 0,1,0,1.
- Reverse skew: lane1 99999999 three cycles before lane0 AAAAAAAA -> no output until lane0 arrives; then AAAAAAAA, 99999999 back-to-back.
- Overflow: DEPTH=4, lane1 pushes 5 words while lane0 idle -> `overflow` = 2'b10 after 5th push; later lane0 data releases exactly 4 lane1 words in order.
- Degraded mode: LANES=4, `active_lanes`=1 -> every lane0 word (00000003, 00000004, …) output, `out_lane`=0; lane1–3 valids ignored, `overflow`=0.
- Clamp/wrap: LANES=4, `active_lanes`=0 behaves as 1; `active_lanes`=3 -> `out_lane` sequence 0,1,2,0,1,2.
- Reset mid-stream: assert `reset` with FIFOs partly full -> next cycle `valid_out`=0, `data_out`=0, `overflow`=0; fresh stripe after release output from lane 0 first.
